// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry direction counters, plus a mispredict counter.
// BP_SATURATING_CTR_EN selects 2-bit hysteresis counters; otherwise 1-bit last-outcome.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module branch_predictor #(
    parameter int IDX_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [`WORD_SIZE-1:0] IF_PC,
    output logic [`WORD_SIZE-1:0] predictedPC,
    output logic                  predictTaken,
    input  logic                  update_valid,
    input  logic [`WORD_SIZE-1:0] update_PC,
    input  logic                  update_taken,
    input  logic [`WORD_SIZE-1:0] update_target,
    input  logic                  update_mispredict,
    output logic [`WORD_SIZE-1:0] mispredict_count
);

    localparam int W       = `WORD_SIZE;
    localparam int TW      = W - IDX_BITS;
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam logic [W-1:0] ONE = 1;

    logic          valid  [ENTRIES];
    logic [TW-1:0] tag    [ENTRIES];
    logic [W-1:0]  target [ENTRIES];
    logic [1:0]    ctr    [ENTRIES];

    logic [IDX_BITS-1:0] l_idx;
    logic [TW-1:0]       l_tag;
    logic                l_hit;

    assign l_idx = IF_PC[IDX_BITS-1:0];
    assign l_tag = IF_PC[W-1:IDX_BITS];
    assign l_hit = valid[l_idx] && (tag[l_idx] == l_tag);

    assign predictTaken = l_hit && ctr[l_idx][1];
    assign predictedPC  = predictTaken ? target[l_idx] : IF_PC + ONE;

    logic [IDX_BITS-1:0] u_idx;
    logic [TW-1:0]       u_tag;
    logic                u_hit;
    logic [1:0]          u_ctr;
    logic [1:0]          cur_ctr;

    assign u_idx   = update_PC[IDX_BITS-1:0];
    assign u_tag   = update_PC[W-1:IDX_BITS];
    assign u_hit   = valid[u_idx] && (tag[u_idx] == u_tag);
    assign cur_ctr = ctr[u_idx];

    always_comb begin
        u_ctr = cur_ctr;
`ifdef BP_SATURATING_CTR_EN
        if (update_taken)
            u_ctr = (cur_ctr == 2'b11) ? 2'b11 : cur_ctr + 2'd1;
        else
            u_ctr = (cur_ctr == 2'b00) ? 2'b00 : cur_ctr - 2'd1;
`else
        u_ctr = {update_taken, 1'b0};
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i]  <= 1'b0;
                tag[i]    <= '0;
                target[i] <= '0;
                ctr[i]    <= 2'b01;
            end
        end else if (update_valid) begin
            if (u_hit) begin
                ctr[u_idx] <= u_ctr;
                if (update_taken)
                    target[u_idx] <= update_target;
            end else if (update_taken) begin
                // Taken miss evicts whatever aliases into this slot
                valid[u_idx]  <= 1'b1;
                tag[u_idx]    <= u_tag;
                target[u_idx] <= update_target;
                ctr[u_idx]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            mispredict_count <= '0;
        else if (update_valid && update_mispredict && (mispredict_count != '1))
            mispredict_count <= mispredict_count + ONE;
    end

endmodule
